// File: rtl/sdma_pkg.sv
// rtl/sdma_pkg.sv - shared types and defaults for the comparator period meter
package sdma_pkg;

    localparam int CNT_W    = 18;
    localparam int AVG_LOG2 = 3;

    typedef enum logic [1:0] {IDLE, ARM, MEAS} pm_state_t;

    typedef logic [CNT_W-1:0] period_t;

endpackage

// File: rtl/glitch_filter.sv
// rtl/glitch_filter.sv - two-flop synchroniser, persistence deglitcher and rising-edge pulse
module glitch_filter #(
    parameter int GLITCH_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_in,
    output logic filt,
    output logic rise
);

    localparam int PW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(GLITCH_CYC - 1);

    logic          sync1_q, sync2_q;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          filt_q, filt_d;
    logic          rise_q, rise_d;

    // A new level must be seen on GLITCH_CYC consecutive cycles; any agreeing cycle restarts the count.
    always_comb begin
        pcnt_d = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (pcnt_q == PCNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end
        rise_d = filt_d & ~filt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            pcnt_q  <= '0;
            filt_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= signal_in;
            sync2_q <= sync1_q;
            pcnt_q  <= pcnt_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
        end
    end

    assign filt = filt_q;
    assign rise = rise_q;

endmodule

// File: rtl/comparator_period_meter.sv
// rtl/comparator_period_meter.sv - measures, averages and qualifies the comparator square-wave period
module comparator_period_meter #(
    parameter int CNT_W      = sdma_pkg::CNT_W,
    parameter int GLITCH_CYC = 8,
    parameter int AVG_LOG2   = sdma_pkg::AVG_LOG2,
    parameter int STABLE_TOL = 4,
    parameter int STABLE_N   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal_in,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             stable,
    output logic             timeout
);

    import sdma_pkg::*;

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int MW    = $clog2(STABLE_N + 1);

    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
    localparam logic [AVG_LOG2-1:0] N_LAST    = '1;
    localparam logic [MW-1:0]       MATCH_MAX = MW'(STABLE_N);
    localparam logic [CNT_W:0]      TOL       = (CNT_W + 1)'(STABLE_TOL);

    logic rise;
    logic filt_unused;

    glitch_filter #(
        .GLITCH_CYC(GLITCH_CYC)
    ) u_glitch_filter (
        .clk       (clk),
        .rst       (rst),
        .signal_in (signal_in),
        .filt      (filt_unused),
        .rise      (rise)
    );

    pm_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [AVG_LOG2-1:0]  n_q, n_d;
    logic [CNT_W-1:0]     period_q, period_d;
    logic                 valid_q, valid_d;
    logic [MW-1:0]        match_q, match_d;
    logic                 have_prev_q, have_prev_d;
    logic                 timeout_q, timeout_d;
    logic                 stable_q, stable_d;

    logic [CNT_W-1:0]     sample;
    logic [ACC_W-1:0]     acc_sum;
    logic [CNT_W-1:0]     avg;
    logic [CNT_W-1:0]     diff;
    logic                 within_tol;

    // cnt holds cycles since the last edge minus one, so the edge's sample is the exact period.
    always_comb begin
        sample     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        acc_sum    = acc_q + ACC_W'(sample);
        avg        = CNT_W'(acc_sum >> AVG_LOG2);
        diff       = (avg >= period_q) ? avg - period_q : period_q - avg;
        within_tol = ({1'b0, diff} <= TOL);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        n_d         = n_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        match_d     = match_q;
        have_prev_d = have_prev_q;
        timeout_d   = timeout_q;

        if (!en) begin
            state_d     = IDLE;
            cnt_d       = '0;
            acc_d       = '0;
            n_d         = '0;
            match_d     = '0;
            have_prev_d = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    n_d     = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        state_d   = MEAS;
                        cnt_d     = '0;
                        acc_d     = '0;
                        n_d       = '0;
                        timeout_d = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d       = '0;
                        match_d     = '0;
                        have_prev_d = 1'b0;
                        timeout_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MEAS: begin
                    if (rise) begin
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                        if (n_q == N_LAST) begin
                            acc_d       = '0;
                            n_d         = '0;
                            period_d    = avg;
                            valid_d     = 1'b1;
                            have_prev_d = 1'b1;
                            if (!have_prev_q || !within_tol) begin
                                match_d = '0;
                            end else if (match_q != MATCH_MAX) begin
                                match_d = match_q + MW'(1);
                            end
                        end else begin
                            acc_d = acc_sum;
                            n_d   = n_q + AVG_LOG2'(1);
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        // Lost signal: discard the partial window and re-arm.
                        state_d     = ARM;
                        cnt_d       = '0;
                        acc_d       = '0;
                        n_d         = '0;
                        match_d     = '0;
                        have_prev_d = 1'b0;
                        timeout_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        stable_d = (match_d == MATCH_MAX) && !timeout_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            n_q         <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
            timeout_q   <= 1'b0;
            stable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            n_q         <= n_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            match_q     <= match_d;
            have_prev_q <= have_prev_d;
            timeout_q   <= timeout_d;
            stable_q    <= stable_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign stable       = stable_q;
    assign timeout      = timeout_q;

endmodule
